// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, legal parameter ranges and the parity helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  typedef enum logic [2:0] {
    RX_IDLE      = ST_IDLE,
    RX_START     = ST_START,
    RX_DATA      = ST_DATA,
    RX_PARITY    = ST_PARITY,
    RX_STOP      = ST_STOP,
    RX_WAIT_IDLE = ST_WAIT_IDLE
  } rx_state_t;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 16;
  localparam int OVERSAMPLE_MIN = 8;
  localparam int OVERSAMPLE_MAX = 32;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic calc_parity(input logic [DATA_WIDTH_MAX-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser on the rx pad plus a 3-tap majority filter clocked by the oversample tick.
module uart_rx_sampler (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic rx,
  output logic rx_s,
  output logic rx_m
);

  logic       rx_meta;
  logic [2:0] hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      hist    <= 3'b111;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      if (clk_en) hist <= {hist[1:0], rx_s};
    end
  end

  assign rx_m = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready holding register and framing/overrun flags.
// Define UART_RX_PARITY_EN to expect a parity bit after the data bits.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int data_width = 8,
  parameter int oversample = 16,
  parameter int stop_bits  = 1,
  parameter int parity_odd = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  rx,
  output logic [data_width-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun
);

  if (data_width < DATA_WIDTH_MIN || data_width > DATA_WIDTH_MAX ||
      oversample < OVERSAMPLE_MIN || oversample > OVERSAMPLE_MAX || (oversample % 2) != 0 ||
      stop_bits < 1 || stop_bits > 2 || parity_odd < 0 || parity_odd > 1) begin : g_param_check
    $error("uart_rx_param: illegal parameter set");
  end

  localparam int TW = $clog2(oversample);
  localparam int BW = $clog2(data_width + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(oversample / 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(oversample - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(data_width);
  localparam logic          STOP_LAST = 1'(stop_bits - 1);

  logic                  rx_s;
  logic                  rx_m;
  rx_state_t             state;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  stop_cnt;
  logic [data_width-1:0] shreg;
  logic                  at_mid;
  logic                  at_last;
  logic                  frame_done;

  uart_rx_sampler u_sampler (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .rx     (rx),
    .rx_s   (rx_s),
    .rx_m   (rx_m)
  );

  assign at_mid     = clk_en && (tick_cnt == TICK_MID);
  assign at_last    = clk_en && (tick_cnt == TICK_LAST);
  assign frame_done = (state == RX_STOP) && at_mid && rx_m && (stop_cnt == STOP_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (clk_en) tick_cnt <= at_last ? '0 : tick_cnt + 1'b1;

      case (state)
        RX_IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          stop_cnt <= 1'b0;
          if (!rx_s) state <= RX_START;
        end
        // A start bit that is high at mid-bit was a glitch; otherwise wait for the
        // bit boundary so the data bits are counted on true bit edges.
        RX_START: begin
          if (at_mid && rx_m) state <= RX_IDLE;
          else if (at_last)   state <= RX_DATA;
        end
        RX_DATA: begin
          if (at_mid) begin
            shreg   <= {rx_m, shreg[data_width-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          if (at_last && bit_cnt == BIT_LAST) state <= RX_PARITY;
`else
          if (at_last && bit_cnt == BIT_LAST) state <= RX_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (at_mid)
            par_bad <= rx_m != calc_parity(DATA_WIDTH_MAX'(shreg), 1'(parity_odd));
          if (at_last) state <= RX_STOP;
        end
`endif
        RX_STOP: begin
          if (at_mid) begin
            if (!rx_m) begin
              frame_err <= 1'b1;
              tick_cnt  <= '0;
              state     <= RX_WAIT_IDLE;
            end else if (frame_done) begin
              state <= RX_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        RX_WAIT_IDLE: begin
          if (!rx_s)        tick_cnt <= '0;
          else if (at_last) state    <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase

      if (frame_done && (!data_valid || data_ready)) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else begin
        if (frame_done)               overrun    <= 1'b1;
        if (data_valid && data_ready) data_valid <= 1'b0;
      end
`ifdef UART_RX_PARITY_EN
      parity_err <= frame_done & par_bad;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: serial frames are generated from the bit-level frame
// format and the received words/flag pulses are checked against a queue-based expectation.
module tb_uart_rx_param;

  localparam int DW_A = 8;
  localparam int OS_A = 16;
  localparam int SB_A = 1;
  localparam int DW_B = 5;
  localparam int OS_B = 8;
  localparam int SB_B = 2;
  localparam bit PAR_ODD = 1'b0;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic ready_a = 1'b1;
  logic ready_b = 1'b1;

  logic [DW_A-1:0] dout_a;
  logic [DW_B-1:0] dout_b;
  logic valid_a, fe_a, pe_a, ov_a;
  logic valid_b, fe_b, pe_b, ov_b;

  int total = 0;
  int bad = 0;
  int fe_cnt_a = 0, pe_cnt_a = 0, ov_cnt_a = 0, vcyc_a = 0;
  int fe_cnt_b = 0, pe_cnt_b = 0, ov_cnt_b = 0, vcyc_b = 0;
  logic [15:0] got_a[$];
  logic [15:0] got_b[$];

`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_param #(.data_width(DW_A), .oversample(OS_A), .stop_bits(SB_A), .parity_odd(PAR_ODD)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .rx(rx_a),
    .data_out(dout_a), .data_valid(valid_a), .data_ready(ready_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a)
  );

  uart_rx_param #(.data_width(DW_B), .oversample(OS_B), .stop_bits(SB_B), .parity_odd(PAR_ODD)) dut_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .rx(rx_b),
    .data_out(dout_b), .data_valid(valid_b), .data_ready(ready_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) clk_en <= ~clk_en;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a) vcyc_a++;
      if (valid_a && ready_a) got_a.push_back(16'(dout_a));
      if (fe_a) fe_cnt_a++;
      if (pe_a) pe_cnt_a++;
      if (ov_a) ov_cnt_a++;
      if (valid_b) vcyc_b++;
      if (valid_b && ready_b) got_b.push_back(16'(dout_b));
      if (fe_b) fe_cnt_b++;
      if (pe_b) pe_cnt_b++;
      if (ov_b) ov_cnt_b++;
    end
  end

`ifdef UART_RX_PARITY_EN
  function automatic logic model_parity(input logic [15:0] d, input int dw);
    logic p = PAR_ODD;
    for (int i = 0; i < dw; i++) p ^= d[i];
    return p;
  endfunction
`endif

  // One bit time = os oversample ticks = 2*os clocks (clk_en fires every other clock).
  task automatic drive_bit(input int port, input logic v, input int os);
    if (port == 0) rx_a = v; else rx_b = v;
    repeat (os * 2) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int port, input logic [15:0] data, input int dw, input int os,
                            input int nstop, input logic stop_v);
    drive_bit(port, 1'b0, os);
    for (int i = 0; i < dw; i++) drive_bit(port, data[i], os);
`ifdef UART_RX_PARITY_EN
    drive_bit(port, model_parity(data, dw) ^ par_flip, os);
`endif
    for (int i = 0; i < nstop; i++) drive_bit(port, stop_v, os);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid_a got=%b exp=0", valid_a); end
    total++; if (dout_a !== 8'h00) begin bad++; $display("FAIL reset_dout_a got=%h exp=00", dout_a); end
    total++; if ({fe_a, pe_a, ov_a} !== 3'b000) begin bad++; $display("FAIL reset_flags_a got=%b exp=000", {fe_a, pe_a, ov_a}); end
    total++; if (valid_b !== 1'b0) begin bad++; $display("FAIL reset_valid_b got=%b exp=0", valid_b); end
    total++; if (dout_b !== 5'h00) begin bad++; $display("FAIL reset_dout_b got=%h exp=00", dout_b); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int base = got_a.size();
    int v0 = vcyc_a, f0 = fe_cnt_a, p0 = pe_cnt_a, o0 = ov_cnt_a;
    ready_a = 1'b1;
    send_frame(0, 16'h00A5, DW_A, OS_A, SB_A, 1'b1);
    settle();
    total++; if (got_a.size() != base + 1) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", got_a.size() - base, 1); end
    else begin
      total++; if (got_a[base] !== 16'h00A5) begin bad++; $display("FAIL basic_data got=%h exp=a5", got_a[base]); end
    end
    total++; if (vcyc_a - v0 != 1) begin bad++; $display("FAIL basic_valid_width got=%0d exp=1", vcyc_a - v0); end
    total++; if ((fe_cnt_a - f0) + (pe_cnt_a - p0) + (ov_cnt_a - o0) != 0) begin
      bad++; $display("FAIL basic_flags got=%0d exp=0", (fe_cnt_a - f0) + (pe_cnt_a - p0) + (ov_cnt_a - o0)); end
  endtask

  task automatic test_glitch();
    int base = got_a.size();
    int v0 = vcyc_a, f0 = fe_cnt_a;
    rx_a = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (3 * OS_A * 2) @(posedge clk);
    #1;
    total++; if (got_a.size() != base || vcyc_a != v0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", vcyc_a - v0); end
    total++; if (fe_cnt_a != f0) begin bad++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt_a - f0); end
  endtask

  task automatic test_framing();
    int base = got_a.size();
    int f0 = fe_cnt_a;
    send_frame(0, 16'h003C, DW_A, OS_A, SB_A, 1'b0);
    drive_bit(0, 1'b0, OS_A);
    drive_bit(0, 1'b0, OS_A);
    drive_bit(0, 1'b1, OS_A);
    drive_bit(0, 1'b1, OS_A);
    send_frame(0, 16'h0055, DW_A, OS_A, SB_A, 1'b1);
    settle();
    total++; if (fe_cnt_a - f0 != 1) begin bad++; $display("FAIL framing_err_pulses got=%0d exp=1", fe_cnt_a - f0); end
    total++; if (got_a.size() != base + 1) begin bad++; $display("FAIL framing_word_count got=%0d exp=1", got_a.size() - base); end
    else begin
      total++; if (got_a[base] !== 16'h0055) begin bad++; $display("FAIL framing_next_word got=%h exp=55", got_a[base]); end
    end
  endtask

  task automatic test_overrun();
    int base = got_a.size();
    int o0 = ov_cnt_a;
    ready_a = 1'b0;
    send_frame(0, 16'h0011, DW_A, OS_A, SB_A, 1'b1);
    send_frame(0, 16'h0022, DW_A, OS_A, SB_A, 1'b1);
    settle();
    @(negedge clk);
    total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL overrun_valid got=%b exp=1", valid_a); end
    total++; if (dout_a !== 8'h11) begin bad++; $display("FAIL overrun_hold got=%h exp=11", dout_a); end
    total++; if (ov_cnt_a - o0 != 1) begin bad++; $display("FAIL overrun_pulses got=%0d exp=1", ov_cnt_a - o0); end
    @(posedge clk);
    #1 ready_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL overrun_drain got=%b exp=0", valid_a); end
    total++; if (got_a.size() != base + 1) begin bad++; $display("FAIL overrun_delivered got=%0d exp=1", got_a.size() - base); end
    else begin
      total++; if (got_a[base] !== 16'h0011) begin bad++; $display("FAIL overrun_word got=%h exp=11", got_a[base]); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    int base = got_a.size();
    int v0 = vcyc_a, f0 = fe_cnt_a, p0 = pe_cnt_a, o0 = ov_cnt_a;
    int gap;
    ready_a = 1'b1;
    for (int n = 0; n < 12; n++) begin
      logic [15:0] w;
      w = 16'($urandom_range(0, 255));
      exp_q.push_back(w);
      send_frame(0, w, DW_A, OS_A, SB_A, 1'b1);
      gap = (n % 3 == 0) ? 0 : $urandom_range(1, 64);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    settle();
    total++; if (got_a.size() != base + exp_q.size()) begin
      bad++; $display("FAIL random_count got=%0d exp=%0d", got_a.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < got_a.size(); i++) begin
      total++; if (got_a[base + i] !== exp_q[i]) begin
        bad++; $display("FAIL random_word_%0d got=%h exp=%h", i, got_a[base + i], exp_q[i]); end
    end
    total++; if (vcyc_a - v0 != exp_q.size()) begin bad++; $display("FAIL random_valid_cycles got=%0d exp=%0d", vcyc_a - v0, exp_q.size()); end
    total++; if ((fe_cnt_a - f0) + (pe_cnt_a - p0) + (ov_cnt_a - o0) != 0) begin
      bad++; $display("FAIL random_flags got=%0d exp=0", (fe_cnt_a - f0) + (pe_cnt_a - p0) + (ov_cnt_a - o0)); end
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int base = got_a.size();
    int p0 = pe_cnt_a;
    ready_a = 1'b1;
    par_flip = 1'b0;
    send_frame(0, 16'h0007, DW_A, OS_A, SB_A, 1'b1);
    settle();
    total++; if (pe_cnt_a != p0) begin bad++; $display("FAIL parity_good_err got=%0d exp=0", pe_cnt_a - p0); end
    par_flip = 1'b1;
    send_frame(0, 16'h0007, DW_A, OS_A, SB_A, 1'b1);
    par_flip = 1'b0;
    settle();
    total++; if (pe_cnt_a - p0 != 1) begin bad++; $display("FAIL parity_bad_err got=%0d exp=1", pe_cnt_a - p0); end
    total++; if (got_a.size() != base + 2) begin bad++; $display("FAIL parity_words got=%0d exp=2", got_a.size() - base); end
    else begin
      total++; if (got_a[base] !== 16'h0007 || got_a[base + 1] !== 16'h0007) begin
        bad++; $display("FAIL parity_data got=%h,%h exp=07,07", got_a[base], got_a[base + 1]); end
    end
`else
    total++; if (pe_cnt_a + pe_cnt_b != 0) begin bad++; $display("FAIL parity_tied_zero got=%0d exp=0", pe_cnt_a + pe_cnt_b); end
`endif
  endtask

  task automatic test_dw5_reset();
    int base = got_b.size();
    int f0 = fe_cnt_b, o0 = ov_cnt_b;
    ready_b = 1'b1;
    send_frame(1, 16'h001F, DW_B, OS_B, SB_B, 1'b1);
    settle();
    total++; if (got_b.size() != base + 1) begin bad++; $display("FAIL dw5_first_count got=%0d exp=1", got_b.size() - base); end
    else begin
      total++; if (got_b[base] !== 16'h001F) begin bad++; $display("FAIL dw5_first_word got=%h exp=1f", got_b[base]); end
    end
    drive_bit(1, 1'b0, OS_B);
    drive_bit(1, 1'b0, OS_B);
    drive_bit(1, 1'b1, OS_B);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rx_b = 1'b1;
    @(negedge clk);
    total++; if (valid_b !== 1'b0 || dout_b !== 5'h00) begin bad++; $display("FAIL dw5_post_reset got=%b/%h exp=0/00", valid_b, dout_b); end
    total++; if ({fe_b, pe_b, ov_b} !== 3'b000) begin bad++; $display("FAIL dw5_post_reset_flags got=%b exp=000", {fe_b, pe_b, ov_b}); end
    repeat (4 * OS_B) @(posedge clk);
    #1;
    base = got_b.size();
    send_frame(1, 16'h000A, DW_B, OS_B, SB_B, 1'b1);
    settle();
    total++; if (got_b.size() != base + 1) begin bad++; $display("FAIL dw5_after_count got=%0d exp=1", got_b.size() - base); end
    else begin
      total++; if (got_b[base] !== 16'h000A) begin bad++; $display("FAIL dw5_after_word got=%h exp=0a", got_b[base]); end
    end
    total++; if ((fe_cnt_b - f0) + (ov_cnt_b - o0) != 0) begin
      bad++; $display("FAIL dw5_flags got=%0d exp=0", (fe_cnt_b - f0) + (ov_cnt_b - o0)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_parity();
    test_dw5_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
